// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
package mult_div_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, subtract the divisor if it fits, and record the quotient bit.
module div_restore_step
    import mult_div_pkg::*;
(
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // Remainder stays below the divisor, so 33 bits hold the shifted value.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = shifted[31:0];
            quo_next = {quo[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit
// writing HI/LO for the mfhi/mflo path.
//
// state  | meaning
// IDLE   | waiting for start_mult / start_div
// RUN    | one Booth or restoring iteration per clock, 32 total
// FINISH | sign fix-up, HI/LO write, done pulse
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        start_mult,
    input  logic        start_div,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t      state;
    op_t         op;
    logic [4:0]  count;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic        acc_q1;
    logic [31:0] m_reg;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic [32:0] booth_sum;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // 33-bit add keeps the -2^31 multiplicand case from overflowing A.
    always_comb begin
        booth_sum = {acc_hi[31], acc_hi};
        case ({acc_lo[0], acc_q1})
            2'b01:   booth_sum = {acc_hi[31], acc_hi} + {m_reg[31], m_reg};
            2'b10:   booth_sum = {acc_hi[31], acc_hi} - {m_reg[31], m_reg};
            default: booth_sum = {acc_hi[31], acc_hi};
        endcase
    end

    div_restore_step u_div_step (
        .rem      (acc_hi),
        .quo      (acc_lo),
        .divisor  (m_reg),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    assign quo_fix = neg_q ? (~acc_lo + 32'd1) : acc_lo;
    assign rem_fix = neg_r ? (~acc_hi + 32'd1) : acc_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_MULT;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            acc_q1   <= 1'b0;
            m_reg    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        op     <= OP_MULT;
                        m_reg  <= op_a;
                        acc_hi <= '0;
                        acc_lo <= op_b;
                        acc_q1 <= 1'b0;
                        count  <= '0;
                        dz     <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else if (start_div) begin
                        op     <= OP_DIV;
                        m_reg  <= abs32(op_b);
                        acc_hi <= '0;
                        acc_lo <= abs32(op_a);
                        acc_q1 <= 1'b0;
                        neg_q  <= op_a[31] ^ op_b[31];
                        neg_r  <= op_a[31];
                        count  <= '0;
                        busy   <= 1'b1;
                        if (op_b == 32'd0) begin
                            dz    <= 1'b1;
                            state <= FINISH;
                        end else begin
                            dz    <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (op == OP_MULT) begin
                        acc_hi <= booth_sum[32:1];
                        acc_lo <= {booth_sum[0], acc_lo[31:1]};
                        acc_q1 <= acc_lo[0];
                    end else begin
                        acc_hi <= rem_nxt;
                        acc_lo <= quo_nxt;
                    end
                    count <= count + 5'd1;
                    if (count == LAST)
                        state <= FINISH;
                end
                FINISH: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (!dz) begin
                        if (op == OP_MULT) begin
                            hi_out <= acc_hi;
                            lo_out <= acc_lo;
                        end else begin
                            hi_out <= rem_fix;
                            lo_out <= quo_fix;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit with hand-written corner sequences.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        start_mult;
    logic        start_div;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .op_a       (op_a),
        .op_b       (op_b),
        .start_mult (start_mult),
        .start_div  (start_div),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        is_div;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts one op, optionally pulses start_div at a given cycle, and returns
    // cycles from the start edge to the first done, plus busy-high cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic d, input int inject_at,
                         output int lat, output int busy_cyc, output logic overlap);
        @(negedge clk);
        op_a = a; op_b = b; start_mult = m; start_div = d;
        @(posedge clk);
        #1;
        start_mult = 1'b0; start_div = 1'b0;
        op_a = $urandom; op_b = $urandom;
        lat = 0; busy_cyc = 0; overlap = 1'b0;
        while (lat < 100) begin
            if (busy) busy_cyc++;
            if (busy && done) overlap = 1'b1;
            if (done) break;
            start_div = (lat == inject_at);
            if (lat == inject_at) op_b = 32'd0;
            @(posedge clk);
            #1;
            lat++;
        end
        start_div = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int   lat, bc;
    logic ov;

    initial begin
        vecs[0] = '{32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
        vecs[2] = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000};
        vecs[4] = '{32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000};
        vecs[5] = '{32'd100,      32'd7,        1'b1, 32'd2,        32'd14};
        vecs[6] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'd1,        32'hFFFFFFFD};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001};
        vecs[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001};
        vecs[9] = '{32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFE, 32'd2};

        reset = 1'b1; op_a = '0; op_b = '0; start_mult = 1'b0; start_div = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {hi_out, lo_out}, 64'd0);
        check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].a, vecs[i].b, !vecs[i].is_div, vecs[i].is_div, -1, lat, bc, ov);
            check($sformatf("v%0d hi", i), 64'(hi_out), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d lo", i), 64'(lo_out), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d latency", i), 64'(lat), 64'd33);
            check($sformatf("v%0d busy cycles", i), 64'(bc), 64'd33);
            check($sformatf("v%0d div_zero", i), 64'(div_zero), 64'd0);
            check($sformatf("v%0d busy/done overlap", i), 64'(ov), 64'd0);
        end

        // done is a single-cycle pulse
        @(posedge clk);
        #1;
        check("done pulse width", 64'(done), 64'd0);

        // divide by zero leaves a preloaded HI/LO intact
        do_op(32'h00012345, 32'h10, 1'b1, 1'b0, -1, lat, bc, ov);
        check("preload lo", 64'(lo_out), 64'h00123450);
        do_op(32'd5, 32'd0, 1'b0, 1'b1, -1, lat, bc, ov);
        check("dz latency", 64'(lat), 64'd1);
        check("dz busy cycles", 64'(bc), 64'd1);
        check("dz flag", 64'(div_zero), 64'd1);
        check("dz hi/lo unchanged", {hi_out, lo_out}, {32'd0, 32'h00123450});
        @(posedge clk);
        #1;
        check("dz pulse width", {62'd0, done, div_zero}, 64'd0);

        // both starts high: multiply wins
        do_op(32'd6, 32'd7, 1'b1, 1'b1, -1, lat, bc, ov);
        check("mult wins", {hi_out, lo_out}, {32'd0, 32'd42});
        check("mult wins latency", 64'(lat), 64'd33);

        // start_div (with zero divisor) pulsed mid-multiply is ignored
        do_op(32'd7, 32'hFFFFFFFD, 1'b1, 1'b0, 5, lat, bc, ov);
        check("ignored start hi/lo", {hi_out, lo_out}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        check("ignored start latency", 64'(lat), 64'd33);
        check("ignored start div_zero", 64'(div_zero), 64'd0);

        // reset at iteration 10 of a multiply
        @(negedge clk);
        op_a = 32'd9; op_b = 32'd9; start_mult = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy before reset", 64'(busy), 64'd1);
        do_reset();
        check("mid-run reset hi/lo", {hi_out, lo_out}, 64'd0);
        check("mid-run reset flags", {61'd0, busy, done, div_zero}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("no stale done", {62'd0, done, busy}, 64'd0);

        do_op(32'd3, 32'd4, 1'b1, 1'b0, -1, lat, bc, ov);
        check("post-reset mult", {hi_out, lo_out}, {32'd0, 32'd12});
        check("post-reset latency", 64'(lat), 64'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
